// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite master bridging a command/response handshake (optional watchdog: AXI_LITE_MASTER_TIMEOUT_EN)
module axi_lite_master #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          axi_clk,
    input  logic                          axi_s_rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_we,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          timeout_o,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP
    } state_t;

    state_t state, state_next;

    // AW and W complete independently; each pending flag keeps its valid up until its own handshake
    logic                        aw_pend, w_pend;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    // State register
    always_ff @(posedge axi_clk) begin
        if (axi_s_rst) state <= IDLE;
        else           state <= state_next;
    end

    // Next-state and handshake outputs; cmd_ready is masked while reset is held
    always_comb begin
        state_next    = state;
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        rsp_valid     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !axi_s_rst;
                if (cmd_valid && !axi_s_rst)
                    state_next = cmd_we ? WR_ADDR_DATA : RD_ADDR;
            end
            WR_ADDR_DATA: begin
                m_axi_awvalid = aw_pend;
                m_axi_wvalid  = w_pend;
                if ((!aw_pend || m_axi_awready) && (!w_pend || m_axi_wready))
                    state_next = WR_RESP;
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_next = RSP;
            end
            RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_next = RD_DATA;
            end
            RD_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_next = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command latch, write-channel pending flags and response capture
    always_ff @(posedge axi_clk) begin
        if (axi_s_rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            if (state == IDLE && cmd_valid) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                aw_pend <= cmd_we;
                w_pend  <= cmd_we;
            end
            if (state == WR_ADDR_DATA) begin
                if (m_axi_awready) aw_pend <= 1'b0;
                if (m_axi_wready)  w_pend  <= 1'b0;
            end
            if (state == WR_RESP && m_axi_bvalid) begin
                rsp_rdata <= '0;
                rsp_resp  <= m_axi_bresp;
            end
            if (state == RD_DATA && m_axi_rvalid) begin
                rsp_rdata <= m_axi_rdata;
                rsp_resp  <= m_axi_rresp;
            end
        end
    end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] to_cnt;
    logic          to_flag;
    logic          active;

    assign active    = (state != IDLE) && (state != RSP);
    assign timeout_o = to_flag;

    // Per-state wait counter; restarts on every state change, flag is sticky and never affects the bus
    always_ff @(posedge axi_clk) begin
        if (axi_s_rst) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (!active || state_next != state)
                to_cnt <= '0;
            else if (to_cnt != CW'(TIMEOUT_CYCLES))
                to_cnt <= to_cnt + 1'b1;
            if (active && to_cnt == CW'(TIMEOUT_CYCLES - 1))
                to_flag <= 1'b1;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - directed and randomized bench for axi_lite_master with a delay-programmable slave
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout_o;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0, bready;
    logic        arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0, rready;

    axi_lite_master #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
        .axi_clk(clk), .axi_s_rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .timeout_o(timeout_o),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // slave configuration, written by the stimulus before each command
    int          cfg_awd = 0, cfg_wd = 0, cfg_bd = 0, cfg_ard = 0, cfg_rd = 0;
    logic [1:0]  cfg_resp = 2'b00;
    logic [31:0] cfg_rdata = '0;

    // slave-side records
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit          aw_got, w_got, b_pend, r_pend;
    int          b_hs = 0, r_hs = 0, viol = 0;
    logic [3:0]  last_awaddr = '0, last_araddr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    bit          p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs;
    logic [3:0]  p_awaddr, p_araddr, p_wstrb;
    logic [31:0] p_wdata;
    bit          to_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (timeout_o === 1'b1) to_seen = 1;

    // Slave: readies/valids change on the falling edge; a handshake is recorded when both are high here
    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0;
        end else begin
            if (p_awv && !p_awhs && !(awvalid === 1'b1 && awaddr === p_awaddr)) viol++;
            if (p_wv && !p_whs && !(wvalid === 1'b1 && wdata === p_wdata && wstrb === p_wstrb)) viol++;
            if (p_arv && !p_arhs && !(arvalid === 1'b1 && araddr === p_araddr)) viol++;
            if ((p_awhs && awvalid) || (p_whs && wvalid) || (p_arhs && arvalid)) viol++;
            if (awprot !== 3'b000 || arprot !== 3'b000) viol++;
            if (bready === 1'b1 && rready === 1'b1) viol++;

            if (b_pend) begin
                if (b_cnt < cfg_bd) begin b_cnt++; bvalid = 0; end
                else begin
                    bvalid = 1; bresp = cfg_resp;
                    if (bready) begin b_hs++; b_pend = 0; b_cnt = 0; end
                end
            end else bvalid = 0;

            if (r_pend) begin
                if (r_cnt < cfg_rd) begin r_cnt++; rvalid = 0; end
                else begin
                    rvalid = 1; rresp = cfg_resp; rdata = cfg_rdata;
                    if (rready) begin r_hs++; r_pend = 0; r_cnt = 0; end
                end
            end else rvalid = 0;

            awready = 0;
            if (awvalid && !aw_got) begin
                if (aw_cnt < cfg_awd) aw_cnt++;
                else begin awready = 1; aw_got = 1; aw_cnt = 0; last_awaddr = awaddr; end
            end
            wready = 0;
            if (wvalid && !w_got) begin
                if (w_cnt < cfg_wd) w_cnt++;
                else begin wready = 1; w_got = 1; w_cnt = 0; last_wdata = wdata; last_wstrb = wstrb; end
            end
            if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
            arready = 0;
            if (arvalid && !r_pend) begin
                if (ar_cnt < cfg_ard) ar_cnt++;
                else begin arready = 1; ar_cnt = 0; r_pend = 1; last_araddr = araddr; end
            end

            p_awv = awvalid; p_awhs = awvalid && awready; p_awaddr = awaddr;
            p_wv = wvalid; p_whs = wvalid && wready; p_wdata = wdata; p_wstrb = wstrb;
            p_arv = arvalid; p_arhs = arvalid && arready; p_araddr = araddr;
        end
    end

    int first_to;

    // One transaction; expected latency from accept: write 3+max(aw,w)+b, read 3+ar+r
    task automatic run_txn(input string tag, input logic we, input logic [3:0] a,
                           input logic [31:0] d, input logic [3:0] s, input logic [1:0] resp,
                           input logic [31:0] rd, input int awd, input int wd, input int bd,
                           input int ard, input int rdd, input int hold);
        int n, lat, exp_lat, b0, hold_bad;
        cfg_awd = awd; cfg_wd = wd; cfg_bd = bd; cfg_ard = ard; cfg_rd = rdd;
        cfg_resp = resp; cfg_rdata = rd;
        @(negedge clk);
        cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        b0 = b_hs;
        @(negedge clk);
        cmd_valid = 0;
        lat = 1; first_to = -1;
        forever begin
            if (timeout_o === 1'b1 && first_to < 0) first_to = lat;
            if (rsp_valid === 1'b1 || lat >= 400) break;
            @(negedge clk); lat++;
        end
        exp_lat = we ? 3 + ((awd > wd) ? awd : wd) + bd : 3 + ard + rdd;
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_rdata"}, rsp_rdata, we ? 32'h0 : rd);
        check({tag, "_resp"}, rsp_resp, resp);
        if (we) begin
            check({tag, "_awaddr"}, last_awaddr, a);
            check({tag, "_wdata"}, {last_wstrb, last_wdata}, {s, d});
        end else begin
            check({tag, "_araddr"}, last_araddr, a);
        end
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_resp !== resp || rsp_rdata !== (we ? 32'h0 : rd) || cmd_ready !== 1'b0)
                hold_bad++;
        end
        check({tag, "_hold_stable"}, hold_bad, 0);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check({tag, "_rsp_done"}, {rsp_valid, cmd_ready}, 2'b01);
        check({tag, "_b_count"}, b_hs - b0, we ? 1 : 0);
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        check("reset_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout_o}, 8'h00);
        check("reset_rsp", {rsp_rdata, rsp_resp}, 34'h0);
        check("reset_addr", {awaddr, wdata, wstrb}, 40'h0);
        rst = 0;
        #1;
        check("ready_after_reset", cmd_ready, 1);

        run_txn("wr_basic", 1, 4'h8, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 0, 0, 0, 0, 0, 0);
        run_txn("rd_basic", 0, 4'h4, 32'h0, 4'h0, 2'b00, 32'h12345678, 0, 0, 0, 0, 0, 0);
        run_txn("wr_wlate", 1, 4'h2, 32'hA5A5_0F0F, 4'h5, 2'b00, 32'h0, 0, 3, 0, 0, 0, 0);
        run_txn("rd_slverr", 0, 4'hC, 32'h0, 4'h0, 2'b10, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 5);
        run_txn("wr_decerr", 1, 4'h1, 32'h0000_1111, 4'h3, 2'b11, 32'h0, 2, 0, 1, 0, 0, 1);

        for (int k = 0; k < 12; k++) begin
            run_txn("rand", 1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom),
                    2'($urandom), $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)));
        end

        // Reset while waiting for BRESP: transaction must vanish without a response
        cfg_awd = 0; cfg_wd = 0; cfg_bd = 10; cfg_resp = 2'b00;
        @(negedge clk);
        cmd_valid = 1; cmd_we = 1; cmd_addr = 4'h6; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check("rst_in_wr_resp_bready", bready, 1);
        rst = 1;
        @(negedge clk);
        check("rst_mid_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 7'h00);
        check("rst_mid_regs", {rsp_rdata, rsp_resp, awaddr}, 38'h0);
        rst = 0;
        #1;
        check("rst_mid_ready_after", cmd_ready, 1);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || bready !== 1'b0) bad++;
        end
        check("rst_mid_no_response", bad, 0);

        run_txn("after_rst", 0, 4'h9, 32'h0, 4'h0, 2'b01, 32'h0BAD_BEEF, 1, 1, 1, 1, 1, 0);
        check("protocol_violations", viol, 0);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        check("no_early_timeout", to_seen, 0);
        // arready withheld 20 cycles: flag set once 16 waiting cycles have elapsed (cycle 17 after accept)
        run_txn("rd_timeout", 0, 4'h3, 32'h0, 4'h0, 2'b00, 32'h7777_1234, 0, 0, 0, 20, 0, 0);
        check("timeout_first_cycle", first_to, 17);
        check("timeout_sticky", timeout_o, 1);
        run_txn("post_timeout", 1, 4'hA, 32'h1234_5678, 4'hF, 2'b00, 32'h0, 0, 0, 0, 0, 0, 0);
        check("timeout_still_set", timeout_o, 1);
`else
        run_txn("rd_long_wait", 0, 4'h3, 32'h0, 4'h0, 2'b00, 32'h7777_1234, 0, 0, 0, 20, 0, 0);
        check("timeout_never", to_seen, 0);
`endif
        check("protocol_violations_end", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameters SHALL be: AXI_DATA_WIDTH, default 32, data width (multiple of 8); AXI_ADDR_WIDTH, default 4, address width; TIMEOUT_CYCLES, default 256, watchdog limit (>=2).
REQ-002 The module SHALL have one clock and a synchronous, active-high reset. Ports (name direction width meaning):
- axi_clk  in  1  single clock, all logic on rising edge
- axi_s_rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted
- cmd_we  in  1  1=write, 0=read
- cmd_addr  in  AXI_ADDR_WIDTH  target address
- cmd_wdata  in  AXI_DATA_WIDTH  write data
- cmd_wstrb  in  AXI_DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  AXI_DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP of the transaction
- timeout_o  out  1  sticky watchdog flag
- m_axi_aw{addr,prot,valid}/awready, m_axi_w{data,strb,valid}/wready, m_axi_b{resp,valid}/bready, m_axi_ar{addr,prot,valid}/arready, m_axi_r{data,resp,valid}/rready: AXI4-Lite master channels, widths per AXI_DATA_WIDTH/AXI_ADDR_WIDTH, prot 3, resp 2.

Function
REQ-003 FSM states SHALL be IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP; one transaction outstanding at a time.
REQ-004 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&cmd_ready, addr/wdata/wstrb/we SHALL be latched and FSM moves to WR_ADDR_DATA (we=1) or RD_ADDR (we=0).
REQ-005 In WR_ADDR_DATA, awvalid and wvalid SHALL both assert the cycle after acceptance and each SHALL deassert independently the cycle after its own handshake; FSM SHALL enter WR_RESP after both handshakes, including same-cycle awready&wready.
REQ-006 awvalid/wvalid/arvalid SHALL never drop before handshake; addr/data/strb SHALL be stable while valid.
REQ-007 In WR_RESP bready SHALL be 1; on bvalid, rsp_resp<=bresp, rsp_rdata<=0, FSM -> RSP.
REQ-008 In RD_ADDR arvalid SHALL be 1 until arready, then RD_DATA; in RD_DATA rready SHALL be 1; on rvalid, rsp_rdata<=rdata, rsp_resp<=rresp, FSM -> RSP.
REQ-009 bready/rready SHALL be 0 outside WR_RESP/RD_DATA.
REQ-010 In RSP rsp_valid SHALL be 1 with stable rsp_rdata/rsp_resp until rsp_ready, then IDLE; no new command accepted in the same cycle.
REQ-011 awprot and arprot SHALL be constant 3'b000.
REQ-012 Minimum latency with zero-wait slave: command accept to rsp_valid SHALL be 3 cycles (write and read).
REQ-013 Non-OKAY responses (2'b10, 2'b11) SHALL be passed through unmodified; no retry.

Reset
REQ-014 With axi_s_rst=1 at a rising edge: FSM=IDLE; cmd_ready, every valid and ready output, rsp_valid, timeout_o SHALL be 0 next cycle; rsp_rdata, rsp_resp, latched address/data SHALL be 0.
REQ-015 Reset mid-transaction SHALL abandon the transaction immediately; no response SHALL be issued for it.
REQ-016 cmd_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-017 Macro AXI_LITE_MASTER_TIMEOUT_EN SHALL control the watchdog.
REQ-018 With AXI_LITE_MASTER_TIMEOUT_EN defined: a counter SHALL clear on entering any non-IDLE/non-RSP state, increment each cycle in WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, and when it reaches TIMEOUT_CYCLES timeout_o SHALL set and stay 1 until reset; the transaction SHALL continue unaltered (AXI rules preserved).
REQ-019 Without the macro: no counter SHALL be built; timeout_o SHALL be constant 0.

Verification
REQ-020 Write addr=4'h8 data=32'hDEADBEEF strb=4'hF, zero-wait slave, bresp=0 -> AW/W match, rsp_valid 3 cycles after accept, rsp_resp=0, rsp_rdata=0.
REQ-021 Read addr=4'h4, slave rdata=32'h12345678 rresp=0 -> rsp_rdata=32'h12345678, rsp_resp=0.
REQ-022 Write, wready 3 cycles after awready -> awvalid drops after AW handshake, wvalid held until wready, one response only.
REQ-023 Read with rresp=2'b10, rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_resp=2'b10 stable 5 cycles, cmd_ready 0 throughout.
REQ-024 Reset asserted while in WR_RESP -> all valids/readies 0 next cycle, no rsp_valid, cmd_ready=1 after release.
REQ-025 With AXI_LITE_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready withheld 20 cycles -> timeout_o=1 from cycle 16, read still completes, timeout_o stays 1; without macro timeout_o=0.
